// File: rtl/rggen_bit_field_access_arbiter.sv
// Arbitrates several requesters onto one shared bit field. Each accepted
// request produces exactly one access cycle toward the field, followed by a
// response that is held until the granted requester accepts it.
`timescale 1ns/1ps

module rggen_bit_field_access_arbiter #(
   parameter int WIDTH      = 8,
   parameter int REQUESTERS = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [REQUESTERS-1:0]         i_req_valid,
   input  logic [REQUESTERS-1:0]         i_req_read,
   input  logic [REQUESTERS-1:0]         i_req_write,
   input  logic [REQUESTERS*WIDTH-1:0]   i_req_mask,
   input  logic [REQUESTERS*WIDTH-1:0]   i_req_data,
   output logic [REQUESTERS-1:0]         o_req_ready,
   output logic [REQUESTERS-1:0]         o_resp_valid,
   input  logic [REQUESTERS-1:0]         i_resp_ready,
   output logic [WIDTH-1:0]              o_resp_data,
   output logic                          o_bit_field_valid,
   output logic [WIDTH-1:0]              o_bit_field_read_mask,
   output logic [WIDTH-1:0]              o_bit_field_write_mask,
   output logic [WIDTH-1:0]              o_bit_field_write_data,
   input  logic [WIDTH-1:0]              i_bit_field_read_data,
   output logic                          o_busy
);

   localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam logic [IW:0] REQ_COUNT = (IW+1)'(REQUESTERS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   state_e              r_state;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_grant;
   logic                r_read;
   logic                r_write;
   logic [WIDTH-1:0]    r_mask;
   logic [WIDTH-1:0]    r_data;
   logic [WIDTH-1:0]    r_resp_data;

   logic [2*REQUESTERS-1:0] w_valid_dbl;
   logic [REQUESTERS-1:0]   w_valid_rot;
   logic [IW-1:0]           w_offset;
   logic [IW:0]             w_grant_sum;
   logic [IW-1:0]           w_grant;
   logic                    w_handshake;
   logic                    w_sel_read;
   logic                    w_sel_write;
   logic [WIDTH-1:0]        w_sel_mask;
   logic [WIDTH-1:0]        w_sel_data;
   logic                    w_resp_ack;
   logic [IW:0]             w_next_ptr;

   // Round-robin pick: rotate valids so the pointer sits at bit 0, take the
   // lowest set bit, then rotate the offset back to an absolute index.
   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_valid_dbl = {i_req_valid, i_req_valid} >> r_ptr;
      w_valid_rot = w_valid_dbl[REQUESTERS-1:0];
      w_offset    = '0;
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
         if (w_valid_rot[k]) begin
            w_offset = IW'(k);
         end
      end
      w_grant_sum = {1'b0, r_ptr} + {1'b0, w_offset};
      if (w_grant_sum >= REQ_COUNT) begin
         w_grant_sum = w_grant_sum - REQ_COUNT;
      end
      w_grant     = w_grant_sum[IW-1:0];
      w_handshake = (r_state == ST_IDLE) && (|i_req_valid);
   end

   // Multiplex the granted requester's attributes and decode one-hot ready.
   always_comb begin
      w_sel_read  = 1'b0;
      w_sel_write = 1'b0;
      w_sel_mask  = '0;
      w_sel_data  = '0;
      o_req_ready = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (w_grant == IW'(k)) begin
            w_sel_read     = i_req_read[k];
            w_sel_write    = i_req_write[k];
            w_sel_mask     = i_req_mask[k*WIDTH +: WIDTH];
            w_sel_data     = i_req_data[k*WIDTH +: WIDTH];
            o_req_ready[k] = w_handshake;
         end
      end
   end

   // Response valid goes only to the latched grant; other requesters' ready is ignored.
   always_comb begin
      o_resp_valid = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         o_resp_valid[k] = (r_state == ST_RESP) && (r_grant == IW'(k));
      end
      w_resp_ack = |(o_resp_valid & i_resp_ready);
      w_next_ptr = {1'b0, r_grant} + (IW+1)'(1);
      if (w_next_ptr >= REQ_COUNT) begin
         w_next_ptr = '0;
      end
   end

   // Transaction FSM: accept in IDLE, one access cycle, then hold the response.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_grant     <= '0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_mask      <= '0;
         r_data      <= '0;
         r_resp_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_handshake) begin
                  r_grant <= w_grant;
                  r_read  <= w_sel_read;
                  r_write <= w_sel_write;
                  r_mask  <= w_sel_mask;
                  r_data  <= w_sel_data;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_resp_data <= i_bit_field_read_data;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (w_resp_ack) begin
                  r_ptr   <= w_next_ptr[IW-1:0];
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Field-side outputs are decoded purely from registered state, so they are
   // active for exactly the one ACCESS cycle and clear at once on reset.
   always_comb begin
      o_bit_field_valid      = (r_state == ST_ACCESS);
      o_bit_field_read_mask  = (o_bit_field_valid && r_read)  ? r_mask : '0;
      o_bit_field_write_mask = (o_bit_field_valid && r_write) ? r_mask : '0;
      o_bit_field_write_data = o_bit_field_valid ? r_data : '0;
      o_resp_data            = r_resp_data;
      o_busy                 = (r_state != ST_IDLE);
   end

endmodule
